uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Transmit-side controller for the UART. It arbitrates two byte sources round-robin and gates the TX baud generator through baud_en. It consumes the generator's one-cycle tx_tick pulse and serialises the granted byte as an 8N1 frame by default, with optional parity and a second stop bit. It sits between the byte producers and the tx_baud_generator / TX pin.

Parameters:
DATA_BITS, 8, data bits per frame, range 5..8, sent LSB first
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tx_tick  in  1  one-cycle bit-period pulse from the baud generator
baud_en  out  1  enable to the baud generator
req0_valid  in  1  requester 0 has a byte
req0_data  in  DATA_BITS  requester 0 byte
req0_ready  out  1  one-cycle accept strobe to requester 0
req1_valid  in  1  requester 1 has a byte
req1_data  in  DATA_BITS  requester 1 byte
req1_ready  out  1  one-cycle accept strobe to requester 1
tx_serial  out  1  UART line; idles high
busy  out  1  a frame is in progress (SYNC through STOP)
grant_id  out  1  source of the current or last frame

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, tx_serial=1, baud_en=0, reqX_ready=0, busy=0, grant_id=0, rr_last=1 (requester 0 wins the first contest). All outputs are registered.
- Arbitration (IDLE only):
  - If exactly one valid is high, that requester wins.
  - If both are high, the requester that is not rr_last wins.
  - On the accept cycle: pulse the winner's ready for 1 cycle, latch its data into the shift register, set grant_id=winner and rr_last=winner, set busy=1, and go to SYNC.
  - Requesters hold valid and data stable until ready is seen; the transfer occurs when valid and ready are both high.
- baud_en: set to 1 on the accept cycle. It stays 1 while busy. It also stays 1 in IDLE if a valid is pending at frame end. Otherwise it clears to 0 in the cycle after the final stop bit completes.
- SYNC: the generator's count is not cleared while disabled, so the controller waits for the first tx_tick with tx_serial=1. On that tick it drives tx_serial=0 and goes to START. Every bit therefore lasts exactly one full tick period.
- START: on tx_tick, drive data bit 0 and go to DATA with bit_cnt=0.
- DATA: on each tx_tick, shift right and drive the next bit. After bit DATA_BITS-1 completes, go to PARITY if PARITY_EN, else go to STOP and drive 1.
- PARITY: the bit value is the XOR of the data bits, inverted if PARITY_ODD. On tx_tick, go to STOP and drive 1.
- STOP: lasts STOP_BITS tick periods. On the last tick, return to IDLE with busy=0 and tx_serial=1.
- Back-to-back: if a valid is pending when IDLE is entered, accept it in the next cycle (arbitration as above). The next frame is tick-aligned via SYNC, so there is no idle gap beyond the SYNC wait (at most one tick period).
- Transitions happen only on tx_tick. A tx_tick arriving in IDLE is ignored. A valid that drops before ready is simply not granted; no error is raised.
- Mid-frame reset: the line returns high immediately and the frame is abandoned. rr_last=1 again.
- Frame length without SYNC = (1 + DATA_BITS + PARITY_EN + STOP_BITS) tick periods.

Test Plan:
1. Only req0 valid, data 0x55, defaults → req0_ready 1-cycle pulse. After SYNC, tx_serial = 0,1,0,1,0,1,0,1,0,1, each held exactly one tick period. busy falls and baud_en=0 one cycle later.
2. req0 and req1 both valid continuously with 0xA1 and 0x3C → grants alternate 0,1,0,1. grant_id follows, frames are back-to-back, and baud_en never drops.
3. PARITY_EN=1, PARITY_ODD=0, data 0x07 → the parity bit after the data bits = 1. With PARITY_ODD=1 → the parity bit = 0.
4. STOP_BITS=2, DATA_BITS=7, data 0x7F → the line is high for 2 tick periods after bit 6. Total frame = 10 ticks after SYNC.
5. Assert rst during DATA bit 3 → tx_serial=1, busy=0, baud_en=0 asynchronously. A new req1-only request afterwards is granted, and a subsequent contest goes to req0.
6. Pulse tx_tick while in IDLE and drop req1_valid before it is granted → no state change, no ready, tx_serial remains 1.

Source files
------------

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit-side controller for the UART. Arbitrates two byte producers
// round-robin, gates the external TX baud generator through baud_en and
// serialises the granted byte as a UART frame (start, DATA_BITS data bits LSB
// first, optional parity, STOP_BITS stop bits), advancing only on tx_tick.
//
// Parameters:
//   DATA_BITS  : data bits per frame, 5..8
//   PARITY_EN  : 1 inserts a parity bit after the data bits
//   PARITY_ODD : 0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
//   STOP_BITS  : number of stop bits, 1 or 2
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset
//   tx_tick     in   one-cycle bit-period pulse from the baud generator
//   baud_en     out  enable to the baud generator
//   req0_valid  in   requester 0 has a byte
//   req0_data   in   requester 0 byte
//   req0_ready  out  one-cycle accept strobe to requester 0
//   req1_valid  in   requester 1 has a byte
//   req1_data   in   requester 1 byte
//   req1_ready  out  one-cycle accept strobe to requester 1
//   tx_serial   out  UART line, idles high
//   busy        out  a frame is in progress (SYNC through STOP)
//   grant_id    out  source of the current or last frame
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_tick,
    output logic                 baud_en,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx_serial,
    output logic                 busy,
    output logic                 grant_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic       PAR_INV    = 1'(PARITY_ODD);
    localparam logic       HAS_PARITY = (PARITY_EN != 0);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_rr_last;
    logic                 r_tx;
    logic                 r_baud_en;
    logic                 r_req0_ready;
    logic                 r_req1_ready;
    logic                 r_busy;
    logic                 r_grant_id;

    logic                 w_any_valid;
    logic                 w_winner;
    logic [DATA_BITS-1:0] w_win_data;

    // A lone requester always wins; in a contest the one that did not win
    // last time gets the grant.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_winner    = (req0_valid & req1_valid) ? ~r_rr_last : req1_valid;
    assign w_win_data  = w_winner ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_rr_last    <= 1'b1;
            r_tx         <= 1'b1;
            r_baud_en    <= 1'b0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_grant_id   <= 1'b0;
        end else begin
            // NOTE: these non-blocking defaults are overridden by a later
            // assignment in the same block, so ready is a single-cycle pulse.
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    // tx_tick is deliberately ignored here.
                    if (w_any_valid) begin
                        r_req0_ready <= ~w_winner;
                        r_req1_ready <= w_winner;
                        r_shift      <= w_win_data;
                        r_parity     <= (^w_win_data) ^ PAR_INV;
                        r_grant_id   <= w_winner;
                        r_rr_last    <= w_winner;
                        r_busy       <= 1'b1;
                        r_baud_en    <= 1'b1;
                        r_state      <= S_SYNC;
                    end else begin
                        // Baud enable lingers one cycle after the last stop
                        // bit so a back-to-back request keeps it high.
                        r_baud_en <= 1'b0;
                    end
                end

                S_SYNC: begin
                    // The generator keeps its count while disabled, so the
                    // start bit is aligned to the first tick seen here.
                    if (tx_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (tx_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (tx_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (HAS_PARITY) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (tx_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (tx_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign baud_en    = r_baud_en;
    assign req0_ready = r_req0_ready;
    assign req1_ready = r_req1_ready;
    assign tx_serial  = r_tx;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Self-checking bench for uart_tx_sched. Four instances cover the default
// 8N1 frame, even parity, odd parity and 7 data bits with 2 stop bits. A
// free-running tick pulses every TICK_DIV cycles. Line bits are sampled in the
// centre of each tick period; expected frames are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int TICK_DIV = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       tx_tick = 1'b0;
    logic [3:0] v0      = '0;
    logic [3:0] v1      = '0;
    logic [7:0] d0 [4];
    logic [7:0] d1 [4];

    wire  [3:0] tx;
    wire  [3:0] busy;
    wire  [3:0] ben;
    wire  [3:0] rdy0;
    wire  [3:0] rdy1;
    wire  [3:0] gid;

    int n_vec = 0;
    int n_err = 0;

    logic mon_en   = 1'b0;
    logic ben_drop = 1'b0;
    int   tick_cnt = 0;

    always #5 clk = ~clk;

    // Bit-period pulse, changed on the falling edge so it is stable at posedge.
    always @(negedge clk) begin
        tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        tx_tick  = (tick_cnt == 0);
    end

    always @(negedge clk) begin
        if (mon_en && !ben[0]) ben_drop = 1'b1;
    end

    // Default 8N1
    uart_tx_sched u_def (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .baud_en(ben[0]),
        .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
        .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
        .tx_serial(tx[0]), .busy(busy[0]), .grant_id(gid[0])
    );

    // 8E1
    uart_tx_sched #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .baud_en(ben[1]),
        .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
        .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
        .tx_serial(tx[1]), .busy(busy[1]), .grant_id(gid[1])
    );

    // 8O1
    uart_tx_sched #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .baud_en(ben[2]),
        .req0_valid(v0[2]), .req0_data(d0[2]), .req0_ready(rdy0[2]),
        .req1_valid(v1[2]), .req1_data(d1[2]), .req1_ready(rdy1[2]),
        .tx_serial(tx[2]), .busy(busy[2]), .grant_id(gid[2])
    );

    // 7N2
    uart_tx_sched #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .baud_en(ben[3]),
        .req0_valid(v0[3]), .req0_data(d0[3][6:0]), .req0_ready(rdy0[3]),
        .req1_valid(v1[3]), .req1_data(d1[3][6:0]), .req1_ready(rdy1[3]),
        .tx_serial(tx[3]), .busy(busy[3]), .grant_id(gid[3])
    );

    typedef struct {
        int          idx;
        logic        req;
        logic [7:0]  data;
        int          nbits;
        logic [15:0] bits;   // bit i = i-th line bit after SYNC, start first
        string       name;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n posedges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int idx, input logic exp_req, input logic drop_all,
                              input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (rdy0[idx] || rdy1[idx]) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " grant seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " ready id"}, {30'd0, rdy1[idx], rdy0[idx]},
                  exp_req ? 32'd2 : 32'd1);
            check({name, " grant_id"}, 32'(gid[idx]), 32'(exp_req));
            check({name, " busy on accept"}, 32'(busy[idx]), 32'd1);
            check({name, " baud_en on accept"}, 32'(ben[idx]), 32'd1);
            if (drop_all) begin
                v0[idx] = 1'b0;
                v1[idx] = 1'b0;
            end
            cyc(1);
            check({name, " ready one cycle"}, {30'd0, rdy1[idx], rdy0[idx]}, 32'd0);
        end
    endtask

    // Finds the start bit, checks every line bit at its centre, and returns at
    // the cycle the last stop bit completes.
    task automatic check_frame(input int idx, input int nbits, input logic [15:0] exp_bits,
                               input string name, output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            if (tx[idx] === 1'b0) begin
                found = 1'b1;
                break;
            end
            cyc(1);
            waited++;
        end
        check({name, " start bit seen"}, 32'(found), 32'd1);
        if (found) begin
            cyc(TICK_DIV / 2);
            for (int i = 0; i < nbits; i++) begin
                if (i > 0) cyc(TICK_DIV);
                check($sformatf("%s bit%0d", name, i), 32'(tx[idx]), 32'(exp_bits[i]));
            end
            cyc(TICK_DIV / 2 - 1);
            check({name, " busy before end"}, 32'(busy[idx]), 32'd1);
            cyc(1);
            check({name, " busy falls"}, 32'(busy[idx]), 32'd0);
            check({name, " line idle"}, 32'(tx[idx]), 32'd1);
            check({name, " baud_en held at end"}, 32'(ben[idx]), 32'd1);
        end
    endtask

    initial begin
        int   waited;
        logic bad;
        logic found;
        logic exp_g;

        for (int i = 0; i < 4; i++) begin
            d0[i] = '0;
            d1[i] = '0;
        end

        vecs[0] = '{0, 1'b0, 8'h55, 10, 16'h02AA, "8N1 0x55"};
        vecs[1] = '{1, 1'b1, 8'h07, 11, 16'h060E, "8E1 0x07"};
        vecs[2] = '{2, 1'b0, 8'h07, 11, 16'h040E, "8O1 0x07"};
        vecs[3] = '{3, 1'b1, 8'h7F, 10, 16'h03FE, "7N2 0x7F"};
        vecs[4] = '{3, 1'b0, 8'h55, 10, 16'h03AA, "7N2 0x55"};
        vecs[5] = '{1, 1'b0, 8'h55, 11, 16'h04AA, "8E1 0x55"};
        vecs[6] = '{2, 1'b1, 8'h55, 11, 16'h06AA, "8O1 0x55"};

        // ---------------- reset state ----------------
        rst = 1'b0;
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset tx[%0d]", i), 32'(tx[i]), 32'd1);
            check($sformatf("reset busy/ben/rdy/gid[%0d]", i),
                  {27'd0, busy[i], ben[i], rdy0[i], rdy1[i], gid[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(1);

        // ---------------- ticks in IDLE, glitching valid ----------------
        bad = 1'b0;
        #1 v1[0] = 1'b1;
        #1 v1[0] = 1'b0;
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            cyc(1);
            if (rdy0[0] || rdy1[0] || busy[0] || ben[0] || !tx[0]) bad = 1'b1;
        end
        check("idle ticks quiet", 32'(bad), 32'd0);
        check("idle grant_id", 32'(gid[0]), 32'd0);

        // ---------------- continuous contest, alternating grants ----------------
        d0[0] = 8'hA1;
        d1[0] = 8'h3C;
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_g = 1'(g % 2);
            wait_grant(0, exp_g, (g == 3), $sformatf("rr grant%0d", g));
            if (g == 0) mon_en = 1'b1;
            check_frame(0, 10, exp_g ? 16'h0278 : 16'h0342, $sformatf("rr frame%0d", g), waited);
            if (g > 0) check($sformatf("rr gap%0d within one tick", g),
                             32'(waited <= TICK_DIV), 32'd1);
        end
        mon_en = 1'b0;
        check("rr baud_en never dropped", 32'(ben_drop), 32'd0);
        cyc(1);
        check("rr baud_en off after last", 32'(ben[0]), 32'd0);

        // ---------------- table-driven single frames ----------------
        foreach (vecs[n]) begin
            if (vecs[n].req) begin
                d1[vecs[n].idx] = vecs[n].data;
                v1[vecs[n].idx] = 1'b1;
            end else begin
                d0[vecs[n].idx] = vecs[n].data;
                v0[vecs[n].idx] = 1'b1;
            end
            wait_grant(vecs[n].idx, vecs[n].req, 1'b1, vecs[n].name);
            check_frame(vecs[n].idx, vecs[n].nbits, vecs[n].bits, vecs[n].name, waited);
            cyc(1);
            check({vecs[n].name, " baud_en off"}, 32'(ben[vecs[n].idx]), 32'd0);
        end

        // ---------------- reset during data bit 3 ----------------
        d1[0] = 8'h00;
        v1[0] = 1'b1;
        wait_grant(0, 1'b1, 1'b1, "mid-rst pre");
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tx[0] === 1'b0) begin
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        check("mid-rst start seen", 32'(found), 32'd1);
        cyc(4 * TICK_DIV + TICK_DIV / 2);
        check("mid-rst in bit3 line", 32'(tx[0]), 32'd0);
        check("mid-rst in bit3 busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid-rst tx async", 32'(tx[0]), 32'd1);
        check("mid-rst busy async", 32'(busy[0]), 32'd0);
        check("mid-rst baud_en async", 32'(ben[0]), 32'd0);
        check("mid-rst grant_id async", 32'(gid[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1);

        d1[0] = 8'h3C;
        v1[0] = 1'b1;
        wait_grant(0, 1'b1, 1'b1, "post-rst req1");
        check_frame(0, 10, 16'h0278, "post-rst req1", waited);
        cyc(1);

        d0[0] = 8'hA1;
        d1[0] = 8'h3C;
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        wait_grant(0, 1'b0, 1'b1, "post-rst contest");
        check_frame(0, 10, 16'h0342, "post-rst contest", waited);
        cyc(1);
        check("post-rst baud_en off", 32'(ben[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
